// File: rtl/cyclic_prefix_ctrl.sv
// Cyclic-prefix inserter control. A ping-pong symbol RAM is filled by the input stream,
// then each full bank is replayed as its last CP samples followed by the whole symbol.
module cyclic_prefix_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cfg_enable,
    input  logic [3:0]        cfg_nfft_log2,
    input  logic [ADDR_W-1:0] cfg_cp_len,
    input  logic              cfg_err_clr,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic              err_framing,
    output logic [15:0]       sym_count
);

    // state | meaning
    // IDLE  | waiting for full[rb]
    // CP    | replaying the tail of the symbol as prefix
    // BODY  | replaying the whole symbol from address 0
    typedef enum logic [1:0] {ST_IDLE, ST_CP, ST_BODY} rd_state_t;

    localparam logic [3:0]        LOG2_MIN = 4'd3;
    localparam logic [3:0]        LOG2_MAX = 4'(ADDR_W);
    localparam logic [ADDR_W-1:0] ALL_ONES = '1;
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    rd_state_t                    state_q, state_d;
    logic                         wb_q, wb_d, rb_q, rb_d;
    logic [1:0]                   full_q, full_d, set_full, clr_full;
    logic [ADDR_W-1:0]            wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]            rd_addr_q, rd_addr_d;
    logic [1:0][ADDR_W-1:0]       nm1_q, nm1_d, cp_q, cp_d;
    logic                         err_q, err_d;
    logic [15:0]                  sym_q, sym_d;
    logic                         mv_q, mv_d, mu_q, mu_d, ml_q, ml_d;

    logic [3:0]                   log2_clamp;
    logic [ADDR_W-1:0]            cfg_nm1, cfg_cp_sat, wr_nm1, rd_nm1, rd_cp;
    logic                         wr_last, at_end, rd_en_c;

    always_comb begin
        log2_clamp = cfg_nfft_log2;
        if (cfg_nfft_log2 < LOG2_MIN)
            log2_clamp = LOG2_MIN;
        else if (cfg_nfft_log2 > LOG2_MAX)
            log2_clamp = LOG2_MAX;
        cfg_nm1    = ~(ALL_ONES << log2_clamp);
        cfg_cp_sat = (cfg_cp_len > cfg_nm1) ? cfg_nm1 : cfg_cp_len;
    end

    // The bank's latched N is not valid until its first sample lands, so use live cfg there.
    assign wr_nm1   = (wr_cnt_q == '0) ? cfg_nm1 : nm1_q[wb_q];
    assign wr_last  = (wr_cnt_q == wr_nm1);
    assign s_tready = ARESETN & cfg_enable & ~full_q[wb_q];
    assign wr_en    = s_tvalid & s_tready;
    assign wr_bank  = wb_q;
    assign wr_addr  = wr_cnt_q;

    always_comb begin
        wb_d     = wb_q;
        wr_cnt_d = wr_cnt_q;
        nm1_d    = nm1_q;
        cp_d     = cp_q;
        err_d    = err_q;
        set_full = 2'b00;
        if (cfg_err_clr)
            err_d = 1'b0;
        if (wr_en) begin
            if (wr_cnt_q == '0) begin
                nm1_d[wb_q] = cfg_nm1;
                cp_d[wb_q]  = cfg_cp_sat;
            end
            if (s_tlast != wr_last)
                err_d = 1'b1;
            if (wr_last) begin
                set_full[wb_q] = 1'b1;
                wr_cnt_d       = '0;
                wb_d           = ~wb_q;
            end else begin
                wr_cnt_d = wr_cnt_q + ONE;
            end
        end
    end

    assign rd_nm1 = nm1_q[rb_q];
    assign rd_cp  = cp_q[rb_q];
    assign at_end = (rd_addr_q == rd_nm1);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rb_d      = rb_q;
        sym_d     = sym_q;
        clr_full  = 2'b00;
        rd_en_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rb_q]) begin
                    if (rd_cp != '0) begin
                        rd_addr_d = rd_nm1 - rd_cp + ONE;
                        state_d   = ST_CP;
                    end else begin
                        rd_addr_d = '0;
                        state_d   = ST_BODY;
                    end
                end
            end
            ST_CP: begin
                rd_en_c = ~mv_q | m_tready;
                if (rd_en_c) begin
                    if (at_end) begin
                        rd_addr_d = '0;
                        state_d   = ST_BODY;
                    end else begin
                        rd_addr_d = rd_addr_q + ONE;
                    end
                end
            end
            ST_BODY: begin
                rd_en_c = ~mv_q | m_tready;
                if (rd_en_c) begin
                    if (at_end) begin
                        rd_addr_d      = '0;
                        clr_full[rb_q] = 1'b1;
                        rb_d           = ~rb_q;
                        sym_d          = sym_q + 16'd1;
                        state_d        = ST_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flags track the RAM's one-cycle read latency and hold while stalled.
    always_comb begin
        mv_d = mv_q;
        mu_d = mu_q;
        ml_d = ml_q;
        if (rd_en_c) begin
            mv_d = 1'b1;
            mu_d = (state_q == ST_CP);
            ml_d = (state_q == ST_BODY) && at_end;
        end else if (m_tready) begin
            mv_d = 1'b0;
        end
    end

    assign full_d = (full_q | set_full) & ~clr_full;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            full_q    <= 2'b00;
            wr_cnt_q  <= '0;
            rd_addr_q <= '0;
            nm1_q     <= '0;
            cp_q      <= '0;
            err_q     <= 1'b0;
            sym_q     <= '0;
            mv_q      <= 1'b0;
            mu_q      <= 1'b0;
            ml_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            full_q    <= full_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_addr_q <= rd_addr_d;
            nm1_q     <= nm1_d;
            cp_q      <= cp_d;
            err_q     <= err_d;
            sym_q     <= sym_d;
            mv_q      <= mv_d;
            mu_q      <= mu_d;
            ml_q      <= ml_d;
        end
    end

    assign rd_en       = rd_en_c;
    assign rd_bank     = rb_q;
    assign rd_addr     = rd_addr_q;
    assign m_tvalid    = mv_q;
    assign m_tuser     = mu_q;
    assign m_tlast     = ml_q;
    assign err_framing = err_q;
    assign sym_count   = sym_q;

endmodule

// File: tb/tb_cyclic_prefix_ctrl.sv
// Bench for cyclic_prefix_ctrl: behavioural RAM, random back-pressure and a queue of
// expected output beats built from each symbol's data, N and clamped CP.
module tb_cyclic_prefix_ctrl;

    localparam int AW = 10;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          cfg_enable = 1'b0;
    logic [3:0]    cfg_nfft_log2 = 4'd3;
    logic [AW-1:0] cfg_cp_len = '0;
    logic          cfg_err_clr = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          m_tready = 1'b0;
    logic          s_tready, wr_en, wr_bank, rd_en, rd_bank;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          m_tvalid, m_tlast, m_tuser, err_framing;
    logic [15:0]   sym_count;

    logic [15:0]   s_data = '0;
    logic [15:0]   ram [2][1 << AW];
    logic [15:0]   rdata;

    int            total = 0;
    int            bad = 0;
    logic [17:0]   exp_q [$];
    int            exp_sym = 0;
    bit            exp_err = 1'b0;
    int            beats = 0;
    int            wr_seen = 0;
    int            cyc = 0;
    int            t_last_wr = 0;
    int            t_first_rd = 0;
    bit            got_rd = 1'b0;
    bit            rdy_rand = 1'b0;
    bit            en_rand = 1'b0;

    cyclic_prefix_ctrl #(.ADDR_W(AW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable),
        .cfg_nfft_log2(cfg_nfft_log2), .cfg_cp_len(cfg_cp_len), .cfg_err_clr(cfg_err_clr),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .err_framing(err_framing), .sym_count(sym_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge ACLK) begin
        if (wr_en) ram[wr_bank][wr_addr] <= s_data;
        if (rd_en) rdata <= ram[rd_bank][rd_addr];
        cyc <= cyc + 1;
        if (wr_en) wr_seen <= wr_seen + 1;
        if (wr_en && s_tlast) begin
            t_last_wr <= cyc;
            got_rd    <= 1'b0;
        end else if (rd_en && !got_rd) begin
            t_first_rd <= cyc;
            got_rd     <= 1'b1;
        end
    end

    logic [17:0] e;
    always @(negedge ACLK) begin
        if (ARESETN && m_tvalid && m_tready) begin
            beats <= beats + 1;
            if (exp_q.size() == 0) begin
                chk("extra_beat", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", rdata, e[17:2]);
                chk("out_tuser", m_tuser, e[1]);
                chk("out_tlast", m_tlast, e[0]);
            end
        end
    end

    initial forever begin
        @(posedge ACLK);
        #1;
        if (rdy_rand) m_tready = 1'($urandom_range(0, 1));
    end

    // Expected stream: last CP samples flagged as prefix, then all N samples, tlast on the final one.
    task automatic send_sym(input int l2, input int cp, input bit seq, input int bad_at);
        int n, c, l2c, tmo;
        bit acc, lst;
        logic [15:0] d [$];
        l2c = (l2 < 3) ? 3 : ((l2 > AW) ? AW : l2);
        n   = 1 << l2c;
        c   = (cp > n - 1) ? n - 1 : cp;
        for (int i = 0; i < n; i++) d.push_back(seq ? 16'(i + 1) : 16'($urandom));
        for (int i = n - c; i < n; i++) exp_q.push_back({d[i], 1'b1, 1'b0});
        for (int i = 0; i < n; i++) exp_q.push_back({d[i], 1'b0, 1'(i == n - 1)});
        exp_sym++;
        cfg_nfft_log2 = 4'(l2);
        cfg_cp_len    = AW'(cp);
        for (int i = 0; i < n; i++) begin
            lst = (bad_at >= 0) ? (i == bad_at) : (i == n - 1);
            if (lst != (i == n - 1)) exp_err = 1'b1;
            if (en_rand && $urandom_range(0, 5) == 0) begin
                cfg_enable = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge ACLK);
                #1;
                cfg_enable = 1'b1;
            end
            s_tvalid = 1'b1;
            s_data   = d[i];
            s_tlast  = lst;
            tmo = 0;
            do begin
                @(negedge ACLK);
                acc = s_tready;
                @(posedge ACLK);
                #1;
                tmo++;
            end while (!acc && tmo < 20000);
            if (!acc) begin
                chk("send_timeout", acc, 1);
                s_tvalid = 1'b0;
                return;
            end
            if (i == 0 && en_rand) begin
                cfg_cp_len    = AW'($urandom);
                cfg_nfft_log2 = 4'($urandom);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 30000) begin
            @(posedge ACLK);
            #1;
            t++;
        end
        if (t >= 30000) chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge ACLK);
        #1;
    endtask

    int base, b0, t;
    initial begin
        cfg_enable = 1'b1;
        m_tready   = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_outputs", {wr_en, rd_en, m_tvalid, m_tlast, m_tuser, err_framing}, 0);
        chk("rst_sym_count", sym_count, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        chk("idle_s_tready", s_tready, 1);

        // Basic symbol: 1..8 with CP=2
        send_sym(3, 2, 1'b1, -1);
        wait_drain();
        chk("basic_sym_count", sym_count, 16'(exp_sym));
        chk("basic_err", err_framing, 0);
        chk("rd_latency", t_first_rd - t_last_wr, 2);

        // CP and N boundaries
        send_sym(3, 0, 1'b0, -1);
        send_sym(3, 9, 1'b0, -1);
        send_sym(1, 3, 1'b0, -1);
        send_sym(12, 5, 1'b0, -1);
        wait_drain();
        chk("bound_sym_count", sym_count, 16'(exp_sym));

        // Back-pressure fills both banks
        m_tready = 1'b0;
        base = wr_seen;
        send_sym(3, 2, 1'b0, -1);
        send_sym(3, 2, 1'b0, -1);
        repeat (4) @(posedge ACLK);
        #1;
        chk("bp_s_tready", s_tready, 0);
        chk("bp_accepted", wr_seen - base, 16);
        fork
            send_sym(3, 2, 1'b0, -1);
            begin
                repeat (6) @(posedge ACLK);
                #1;
                chk("bp_held", wr_seen - base, 16);
                m_tready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_release_ready", s_tready, 1);
        chk("bp_sym_count", sym_count, 16'(exp_sym));

        // Random m_tready
        rdy_rand = 1'b1;
        send_sym(3, 2, 1'b1, -1);
        send_sym(3, 2, 1'b1, -1);
        send_sym(4, 5, 1'b0, -1);
        wait_drain();
        rdy_rand = 1'b0;
        m_tready = 1'b1;
        chk("rand_rdy_sym_count", sym_count, 16'(exp_sym));

        // Framing error: tlast on sample 5 of 8
        send_sym(3, 2, 1'b0, 4);
        wait_drain();
        chk("framing_err_set", err_framing, 32'(exp_err));
        chk("framing_sym_count", sym_count, 16'(exp_sym));
        cfg_err_clr = 1'b1;
        @(posedge ACLK);
        #1;
        cfg_err_clr = 1'b0;
        exp_err = 1'b0;
        chk("framing_err_clr", err_framing, 32'(exp_err));

        // Random traffic with enable stalls and mid-symbol cfg changes
        rdy_rand = 1'b1;
        en_rand  = 1'b1;
        for (int k = 0; k < 12; k++) send_sym($urandom_range(3, 5), $urandom_range(0, 40), 1'b0, -1);
        wait_drain();
        en_rand  = 1'b0;
        rdy_rand = 1'b0;
        m_tready = 1'b1;
        cfg_enable = 1'b1;
        chk("rand_err", err_framing, 32'(exp_err));
        chk("rand_sym_count", sym_count, 16'(exp_sym));

        // Reset during BODY
        b0 = beats;
        send_sym(3, 2, 1'b1, -1);
        t = 0;
        while (beats - b0 < 5 && t < 200) begin
            @(posedge ACLK);
            #1;
            t++;
        end
        chk("mid_reset_reached_body", beats - b0 >= 5, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("mid_reset_outputs", {s_tready, wr_en, rd_en, m_tvalid, m_tlast, m_tuser, err_framing}, 0);
        chk("mid_reset_sym_count", sym_count, 0);
        exp_q.delete();
        exp_sym = 0;
        exp_err = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        send_sym(3, 2, 1'b1, -1);
        wait_drain();
        chk("post_reset_sym_count", sym_count, 16'(exp_sym));
        chk("post_reset_latency", t_first_rd - t_last_wr, 2);
        chk("post_reset_err", err_framing, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
